// File: rtl/bnnroll_pkg.sv
// Shared state encoding and width helpers for the rolled BNN classifier control path.
// Pure declarations: no timing, no flow control.
package bnnroll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HID  = 2'd1,
    ST_CLS  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Index widths never collapse to zero bits, even for a single-entry range.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Class score is a popcount over all hidden bits, so it must hold HIDDEN_CNT itself.
  function automatic int sum_bits(input int hidden_cnt);
    return clog2_min1(hidden_cnt + 1);
  endfunction

endpackage

// File: rtl/bnnroll_argmax_tracker.sv
// Running argmax over serially presented class scores; strict greater-than so ties keep the lowest index.
// Best values include the current cycle's score combinationally; state updates on the same edge.
module bnnroll_argmax_tracker #(
  parameter int IDX_W   = 3,
  parameter int SCORE_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic               first_i,
  input  logic [IDX_W-1:0]   idx_i,
  input  logic [SCORE_W-1:0] score_i,
  output logic [IDX_W-1:0]   best_idx_o,
  output logic [SCORE_W-1:0] best_score_o
);

  logic [IDX_W-1:0]   best_idx_q, best_idx_d;
  logic [SCORE_W-1:0] best_score_q, best_score_d;

  always_comb begin
    best_idx_d   = best_idx_q;
    best_score_d = best_score_q;
    if (en_i && (first_i || (score_i > best_score_q))) begin
      best_idx_d   = idx_i;
      best_score_d = score_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_idx_q   <= '0;
      best_score_q <= '0;
    end else begin
      best_idx_q   <= best_idx_d;
      best_score_q <= best_score_d;
    end
  end

  assign best_idx_o   = best_idx_d;
  assign best_score_o = best_score_d;

endmodule

// File: rtl/bnnroll_seq_ctrl.sv
// Sequences the rolled BNN datapath: one hidden neuron per cycle, then one class per cycle with argmax.
// Result valid HIDDEN_CNT+CLASS_CNT+1 cycles after accept; out_valid holds until out_ready, one sample in flight.
module bnnroll_seq_ctrl
  import bnnroll_pkg::*;
#(
  parameter  int HIDDEN_CNT = 40,
  parameter  int CLASS_CNT  = 6,
  localparam int SUM_BITS   = sum_bits(HIDDEN_CNT),
  localparam int HID_W      = clog2_min1(HIDDEN_CNT),
  localparam int CLS_W      = clog2_min1(CLASS_CNT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                feat_load,
  output logic                hid_en,
  output logic [HID_W-1:0]    hid_idx,
  output logic                cls_en,
  output logic [CLS_W-1:0]    cls_idx,
  input  logic [SUM_BITS-1:0] cls_score,
  output logic [CLS_W-1:0]    prediction,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);

  localparam logic [HID_W-1:0] HID_LAST = HID_W'(HIDDEN_CNT - 1);
  localparam logic [CLS_W-1:0] CLS_LAST = CLS_W'(CLASS_CNT - 1);

  state_e              state_q, state_d;
  logic [HID_W-1:0]    hid_idx_q, hid_idx_d;
  logic [CLS_W-1:0]    cls_idx_q, cls_idx_d;
  logic [CLS_W-1:0]    prediction_q, prediction_d;
  logic                feat_load_q, feat_load_d;
  logic [CLS_W-1:0]    best_idx;
  logic [SUM_BITS-1:0] best_score_unused;

  // The running best score only matters inside the tracker; the top consumes the index.
  bnnroll_argmax_tracker #(
    .IDX_W   (CLS_W),
    .SCORE_W (SUM_BITS)
  ) u_argmax (
    .clk          (clk),
    .rst          (rst),
    .en_i         (state_q == ST_CLS),
    .first_i      (cls_idx_q == '0),
    .idx_i        (cls_idx_q),
    .score_i      (cls_score),
    .best_idx_o   (best_idx),
    .best_score_o (best_score_unused)
  );

  always_comb begin
    state_d      = state_q;
    hid_idx_d    = hid_idx_q;
    cls_idx_d    = cls_idx_q;
    prediction_d = prediction_q;
    feat_load_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d     = ST_HID;
          feat_load_d = 1'b1;
        end
      end
      ST_HID: begin
        if (hid_idx_q == HID_LAST) begin
          hid_idx_d = '0;
          state_d   = ST_CLS;
        end else begin
          hid_idx_d = hid_idx_q + HID_W'(1);
        end
      end
      ST_CLS: begin
        if (cls_idx_q == CLS_LAST) begin
          cls_idx_d    = '0;
          state_d      = ST_DONE;
          // best_idx already folds in the last class's comparison.
          prediction_d = best_idx;
        end else begin
          cls_idx_d = cls_idx_q + CLS_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      hid_idx_q    <= '0;
      cls_idx_q    <= '0;
      prediction_q <= '0;
      feat_load_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hid_idx_q    <= hid_idx_d;
      cls_idx_q    <= cls_idx_d;
      prediction_q <= prediction_d;
      feat_load_q  <= feat_load_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign hid_en     = (state_q == ST_HID);
  assign cls_en     = (state_q == ST_CLS);
  assign out_valid  = (state_q == ST_DONE);
  assign feat_load  = feat_load_q;
  assign hid_idx    = hid_idx_q;
  assign cls_idx    = cls_idx_q;
  assign prediction = prediction_q;

endmodule

// File: tb/tb_bnnroll_seq_ctrl.sv
// Self-checking bench: default-size controller driven from a score table with a result scoreboard,
// plus a minimum-size (HIDDEN_CNT=1, CLASS_CNT=2) instance exercised cycle by cycle.
module tb_bnnroll_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Default-size DUT
  logic       in_valid = 1'b0, out_ready = 1'b1;
  logic       in_ready, feat_load, hid_en, cls_en, out_valid, busy;
  logic [5:0] hid_idx, cls_score;
  logic [2:0] cls_idx, prediction;

  // Minimum-size DUT
  logic       in_valid1 = 1'b0, out_ready1 = 1'b1;
  logic       in_ready1, feat_load1, hid_en1, cls_en1, out_valid1, busy1;
  logic [0:0] hid_idx1, cls_idx1, prediction1, cls_score1;
  logic       msc [2];

  typedef struct {
    logic [5:0] sc [6];
    int         exp;
  } vec_t;
  vec_t tbl [8];

  int vec_q[$];
  int exp_q[$];
  int gap_q[$];
  int cur_vec = 0;

  int acc_total = 0, hs_total = 0, fl_total = 0;
  int acc_base = 0, hs_cyc = 0;
  int fl_n = 0, fl_rel = -1, hid_n = 0, cls_n = 0, ov_n = 0, ov_first = -1;
  int order_bad = 0;

  assign cls_score  = (cls_idx < 3'd6) ? tbl[cur_vec].sc[cls_idx] : 6'd0;
  assign cls_score1 = msc[cls_idx1];

  bnnroll_seq_ctrl u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .feat_load  (feat_load),
    .hid_en     (hid_en),
    .hid_idx    (hid_idx),
    .cls_en     (cls_en),
    .cls_idx    (cls_idx),
    .cls_score  (cls_score),
    .prediction (prediction),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  bnnroll_seq_ctrl #(.HIDDEN_CNT(1), .CLASS_CNT(2)) u_min (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid1),
    .in_ready   (in_ready1),
    .feat_load  (feat_load1),
    .hid_en     (hid_en1),
    .hid_idx    (hid_idx1),
    .cls_en     (cls_en1),
    .cls_idx    (cls_idx1),
    .cls_score  (cls_score1),
    .prediction (prediction1),
    .out_valid  (out_valid1),
    .out_ready  (out_ready1),
    .busy       (busy1)
  );

  task automatic chk(input string nm, input longint act, input longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic set_vec(input int i, input int a, input int b, input int c,
                         input int d, input int e, input int f, input int ex);
    tbl[i].sc[0] = 6'(a); tbl[i].sc[1] = 6'(b); tbl[i].sc[2] = 6'(c);
    tbl[i].sc[3] = 6'(d); tbl[i].sc[4] = 6'(e); tbl[i].sc[5] = 6'(f);
    tbl[i].exp   = ex;
  endtask

  // Observer for the default DUT: per-sample statistics and the result scoreboard.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (in_valid && in_ready) begin
        gap_q.push_back(cyc - hs_cyc);
        acc_base = cyc; fl_n = 0; fl_rel = -1; hid_n = 0; cls_n = 0;
        ov_n = 0; ov_first = -1; order_bad = 0;
        acc_total++;
      end
      if (feat_load) begin
        if (fl_n == 0) fl_rel = cyc - acc_base;
        fl_n++; fl_total++;
        if (vec_q.size() == 0) chk("unexpected_feat_load", 1, 0);
        else cur_vec = vec_q.pop_front();
      end
      if (hid_en) begin
        if (hid_idx != 6'(hid_n)) order_bad = 1;
        hid_n++;
      end else if (hid_idx != 6'd0) order_bad = 1;
      if (cls_en) begin
        if (cls_idx != 3'(cls_n)) order_bad = 1;
        cls_n++;
      end else if (cls_idx != 3'd0) order_bad = 1;
      if (out_valid) begin
        if (ov_n == 0) ov_first = cyc - acc_base;
        ov_n++;
      end
      if (out_valid && out_ready) begin
        hs_total++; hs_cyc = cyc;
        if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
        else chk("prediction", prediction, exp_q.pop_front());
      end
    end
  end

  task automatic start_sample(input int v);
    int a0, t;
    a0 = acc_total;
    vec_q.push_back(v);
    exp_q.push_back(tbl[v].exp);
    in_valid = 1'b1;
    t = 0;
    while (acc_total == a0 && t < 20) begin @(posedge clk); #1; t++; end
    in_valid = 1'b0;
    chk("accept", acc_total - a0, 1);
  endtask

  task automatic wait_hs(input int h0, input int n, input int budget);
    int t;
    t = 0;
    while (hs_total < h0 + n && t < budget) begin @(posedge clk); #1; t++; end
    chk("result_count", hs_total - h0, n);
  endtask

  task automatic run_one(input int v);
    int h0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    h0 = hs_total;
    start_sample(v);
    wait_hs(h0, 1, 100);
    chk("feat_load_cycle", fl_rel, 1);
    chk("out_valid_cycle", ov_first, 47);
    chk("hid_en_cycles", hid_n, 40);
    chk("cls_en_cycles", cls_n, 6);
    chk("out_valid_cycles", ov_n, 1);
    chk("feat_load_count", fl_n, 1);
    chk("index_sequence", order_bad, 0);
    @(negedge clk);
    chk("prediction_hold", prediction, tbl[v].exp);
    chk("idle_after_result", in_ready, 1);
  endtask

  task automatic min_run(input logic s0, input logic s1, input int ex);
    @(posedge clk); #1;
    msc[0] = s0; msc[1] = s1;
    in_valid1 = 1'b1;
    @(negedge clk);
    chk("min_in_ready", in_ready1, 1);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("min_feat_load", feat_load1, (k == 1));
      chk("min_hid_en", hid_en1, (k == 1));
      chk("min_hid_idx", hid_idx1, 0);
      chk("min_cls_en", cls_en1, (k == 2 || k == 3));
      chk("min_cls_idx", cls_idx1, (k == 3));
      chk("min_out_valid", out_valid1, (k == 4));
      chk("min_busy", busy1, (k <= 4));
    end
    chk("min_prediction", prediction1, ex);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, h0, t, f0;
    bit found;
    set_vec(0,  3,  9,  4, 12,  7,  1, 3);
    set_vec(1,  5, 11, 11,  2, 11,  0, 1);
    set_vec(2,  0,  0,  0,  0,  0,  0, 0);
    set_vec(3,  1,  2,  3,  4,  5, 40, 5);
    set_vec(4, 40,  0, 40, 40,  0, 40, 0);
    set_vec(5,  7,  6,  5,  8,  8,  9, 5);
    set_vec(6,  2,  2,  3,  3,  1,  0, 2);
    set_vec(7,  0,  0,  0,  0,  0,  1, 5);
    msc[0] = 1'b0; msc[1] = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_feat_load", feat_load, 0);
    chk("rst_hid_en", hid_en, 0);
    chk("rst_cls_en", cls_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_hid_idx", hid_idx, 0);
    chk("rst_cls_idx", cls_idx, 0);
    chk("rst_prediction", prediction, 0);
    chk("rst_min_prediction", prediction1, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table-driven samples
    for (int i = 0; i < 8; i++) run_one(i);

    // Reset in the middle of CLS with a previous prediction of 3
    run_one(0);
    @(posedge clk); #1;
    start_sample(3);
    found = 1'b0;
    t = 0;
    while (!found && t < 100) begin
      @(negedge clk);
      if (cls_en && cls_idx == 3'd3) found = 1'b1;
      t++;
    end
    chk("reached_cls_idx3", found, 1);
    rst = 1'b1;
    #1;
    chk("midrst_prediction", prediction, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_cls_en", cls_en, 0);
    chk("midrst_cls_idx", cls_idx, 0);
    chk("midrst_out_valid", out_valid, 0);
    exp_q.delete();
    vec_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    run_one(1);

    // Backpressure: out_valid held while out_ready is low, in_valid pulses ignored
    @(posedge clk); #1;
    out_ready = 1'b0;
    h0 = hs_total;
    start_sample(5);
    t = 0;
    found = 1'b0;
    while (!found && t < 100) begin
      @(negedge clk);
      if (out_valid) found = 1'b1;
      else begin
        @(posedge clk); #1;
        in_valid = ~in_valid;
        t++;
      end
    end
    chk("bp_out_valid_seen", found, 1);
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      in_valid = (i % 2 == 1);
      @(negedge clk);
      chk("bp_out_valid_held", out_valid, 1);
      chk("bp_prediction", prediction, 5);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_feat_load", feat_load, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_hs(h0, 1, 5);
    chk("bp_out_valid_cycles", ov_n, 11);
    chk("bp_feat_load_count", fl_n, 1);
    chk("bp_out_valid_cycle", ov_first, 47);

    // Back-to-back: in_valid held across three samples
    @(posedge clk); #1;
    gap_q.delete();
    a0 = acc_total; h0 = hs_total; f0 = fl_total;
    vec_q.push_back(6); exp_q.push_back(tbl[6].exp);
    vec_q.push_back(1); exp_q.push_back(tbl[1].exp);
    vec_q.push_back(3); exp_q.push_back(tbl[3].exp);
    in_valid = 1'b1;
    t = 0;
    while (acc_total < a0 + 3 && t < 400) begin @(posedge clk); #1; t++; end
    in_valid = 1'b0;
    chk("b2b_accepts", acc_total - a0, 3);
    wait_hs(h0, 3, 200);
    chk("b2b_feat_loads", fl_total - f0, 3);
    chk("b2b_gap_entries", gap_q.size(), 3);
    if (gap_q.size() == 3) begin
      chk("b2b_gap2", gap_q[1], 1);
      chk("b2b_gap3", gap_q[2], 1);
    end

    // Minimum configuration
    min_run(1'b1, 1'b0, 0);
    min_run(1'b0, 1'b1, 1);
    min_run(1'b1, 1'b1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
